// File: rtl/stitch_sb_pkg.sv
// Shared types and helpers for the scoreboard tracker: drain FSM states,
// the hardwired-zero register index and a one-hot test.
package stitch_sb_pkg;

    typedef enum logic [1:0] {
        SbRun   = 2'd0,
        SbDrain = 2'd1,
        SbDone  = 2'd2
    } sb_drain_e;

    localparam int unsigned SbRegZero = 0;

    // Callers zero-extend their vector, so any width up to 64 bits is supported.
    function automatic logic sb_is_onehot(input logic [63:0] vec);
        return (vec != '0) && ((vec & (vec - 64'd1)) == '0);
    endfunction

endpackage

// File: rtl/stitch_sb_hazard.sv
// RAW/WAW hazard detect: per-slot compare of tracked rd against the checked
// operands, OR-reduced over busy slots that are not masked. Purely combinational.
module stitch_sb_hazard
    import stitch_sb_pkg::*;
#(
    parameter int NumSlots     = 8,
    parameter int RegAddrWidth = 5
) (
    input  logic [NumSlots-1:0]                   busy_i,
    input  logic [NumSlots-1:0][RegAddrWidth-1:0] rd_i,
    input  logic [NumSlots-1:0]                   mask_i,
    input  logic [RegAddrWidth-1:0]               rs1_i,
    input  logic [RegAddrWidth-1:0]               rs2_i,
    input  logic [RegAddrWidth-1:0]               rd_chk_i,
    output logic                                  stall_o
);

    always_comb begin
        stall_o = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            if (busy_i[i] && !mask_i[i] && (rd_i[i] != RegAddrWidth'(SbRegZero)) &&
                ((rd_i[i] == rs1_i) || (rd_i[i] == rs2_i) || (rd_i[i] == rd_chk_i))) begin
                stall_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stitch_sb_tracker.sv
// Scoreboard tracker between issue and writeback; slot IDs come from and return to a one-hot pool.
// Alloc/retire handshakes are zero-latency; hazards are visible one cycle after allocation.
// STITCH_SB_BYPASS_EN masks the slot retiring this cycle out of the hazard check.
module stitch_sb_tracker
    import stitch_sb_pkg::*;
#(
    parameter int NumSlots     = 8,
    parameter int RegAddrWidth = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    alloc_valid_i,
    input  logic [RegAddrWidth-1:0] alloc_rd_i,
    output logic                    alloc_ready_o,
    output logic [NumSlots-1:0]     alloc_id_o,
    input  logic [NumSlots-1:0]     pool_data_i,
    input  logic                    pool_empty_i,
    output logic                    pool_pop_o,
    output logic [NumSlots-1:0]     pool_data_o,
    output logic                    pool_push_o,
    input  logic                    pool_full_i,
    input  logic                    ret_valid_i,
    input  logic [NumSlots-1:0]     ret_id_i,
    output logic                    ret_ready_o,
    input  logic [RegAddrWidth-1:0] chk_rs1_i,
    input  logic [RegAddrWidth-1:0] chk_rs2_i,
    input  logic [RegAddrWidth-1:0] chk_rd_i,
    output logic                    chk_stall_o,
    output logic [NumSlots-1:0]     busy_o,
    input  logic                    drain_req_i,
    output logic                    drain_done_o,
    output logic                    err_o
);

    logic [NumSlots-1:0]                   busy_q, busy_d;
    logic [NumSlots-1:0][RegAddrWidth-1:0] rd_q, rd_d;
    sb_drain_e                             state_q, state_d;
    logic                                  err_q, err_d;
    logic                                  alloc_fire, ret_fire, ret_legal, ret_accept;
    logic [NumSlots-1:0]                   byp_mask;

    // Handshakes are gated by reset so every output reads low while reset is held.
    assign alloc_ready_o = rst_ni && (state_q == SbRun) && !pool_empty_i;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign pool_pop_o    = alloc_fire;
    assign alloc_id_o    = rst_ni ? pool_data_i : '0;

    assign ret_ready_o = rst_ni && !pool_full_i;
    assign ret_fire    = ret_valid_i && ret_ready_o;
    assign ret_legal   = sb_is_onehot(64'(ret_id_i)) && ((busy_q & ret_id_i) != '0);
    assign ret_accept  = ret_fire && ret_legal;
    assign pool_push_o = ret_accept;
    assign pool_data_o = ret_accept ? ret_id_i : '0;

    always_comb begin
        busy_d = busy_q;
        rd_d   = rd_q;
        if (alloc_fire) begin
            busy_d = busy_d | pool_data_i;
        end
        if (ret_accept) begin
            busy_d = busy_d & ~ret_id_i;
        end
        for (int i = 0; i < NumSlots; i++) begin
            if (alloc_fire && pool_data_i[i]) begin
                rd_d[i] = alloc_rd_i;
            end
        end
    end

    assign err_d = err_q || (ret_fire && !ret_legal);

    // Skipping straight to DONE requires no allocation landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SbRun: begin
                if (drain_req_i) begin
                    state_d = ((busy_q == '0) && !alloc_fire) ? SbDone : SbDrain;
                end
            end
            SbDrain: begin
                if (!drain_req_i) begin
                    state_d = SbRun;
                end else if (busy_q == '0) begin
                    state_d = SbDone;
                end
            end
            SbDone: begin
                if (!drain_req_i) begin
                    state_d = SbRun;
                end
            end
            default: state_d = SbRun;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            rd_q    <= '0;
            state_q <= SbRun;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

`ifdef STITCH_SB_BYPASS_EN
    assign byp_mask = ret_accept ? ret_id_i : '0;
`else
    assign byp_mask = '0;
`endif

    stitch_sb_hazard #(
        .NumSlots     (NumSlots),
        .RegAddrWidth (RegAddrWidth)
    ) u_hazard (
        .busy_i   (busy_q),
        .rd_i     (rd_q),
        .mask_i   (byp_mask),
        .rs1_i    (chk_rs1_i),
        .rs2_i    (chk_rs2_i),
        .rd_chk_i (chk_rd_i),
        .stall_o  (chk_stall_o)
    );

    assign busy_o       = busy_q;
    assign drain_done_o = (state_q == SbDone);
    assign err_o        = err_q;

endmodule
